alu_rr_scheduler: RTL and testbench

// - Shares one combinational 32-bit ALU_32bits instance among NUM_REQ requesters.
// - Each requester presents operands and an opcode with a valid/ready handshake.
// - A round-robin arbiter grants one requester at a time.
// - The block drives the ALU from registered operands, registers the ALU result and

---
 rtl/alu_rr_scheduler.sv | 138 +++++++++++++
 tb/tb_alu_rr_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// Round-robin front end that time-shares one combinational ALU among NUM_REQ requesters.
// Each accepted op runs IDLE -> EXEC -> RESP and returns its result tagged with the requester id.
module alu_rr_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int WIDTH   = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_A,
   input  logic [NUM_REQ*WIDTH-1:0] req_B,
   input  logic [NUM_REQ*4-1:0]     req_SelOp,
   output logic [WIDTH-1:0]         alu_A,
   output logic [WIDTH-1:0]         alu_B,
   output logic [3:0]               alu_SelOp,
   input  logic [WIDTH-1:0]         alu_C,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [ID_W-1:0]          resp_id,
   output logic [WIDTH-1:0]         resp_C,
   output logic                     resp_err,
   output logic                     busy
);

   localparam logic [1:0]      IDLE     = 2'd0;
   localparam logic [1:0]      EXEC     = 2'd1;
   localparam logic [1:0]      RESP     = 2'd2;
   localparam logic [3:0]      LAST_OP  = 4'd8;
   localparam logic [ID_W-1:0] PTR_INIT = ID_W'(NUM_REQ - 1);

   logic [1:0]         state_r;
   logic [ID_W-1:0]    lastGrant_r;
   logic [WIDTH-1:0]   aluA_r;
   logic [WIDTH-1:0]   aluB_r;
   logic [3:0]         aluSelOp_r;
   logic [WIDTH-1:0]   respC_r;
   logic [ID_W-1:0]    respId_r;
   logic               respValid_r;
   logic               respErr_r;

   logic [ID_W-1:0]    winner_s;
   logic               found_s;
   logic [WIDTH-1:0]   selA_s;
   logic [WIDTH-1:0]   selB_s;
   logic [3:0]         selOp_s;
   logic [NUM_REQ-1:0] reqReady_s;

   // Round-robin search: first valid requester after the last grant, wrapping.
   always_comb begin
      logic [ID_W-1:0] idx;
      logic            hit;
      winner_s = '0;
      found_s  = 1'b0;
      idx      = '0;
      hit      = 1'b0;
      for (int off = 32'sd1; off <= NUM_REQ; off++) begin
         idx      = ID_W'((int'(lastGrant_r) + off) % NUM_REQ);
         hit      = req_valid[idx] & ~found_s;
         winner_s = hit ? idx : winner_s;
         found_s  = found_s | hit;
      end
   end

   // Operand mux for the winner and the one-hot grant, offered only in IDLE.
   always_comb begin
      selA_s     = '0;
      selB_s     = '0;
      selOp_s    = 4'd0;
      reqReady_s = '0;
      for (int i = 32'sd0; i < NUM_REQ; i++) begin
         selA_s        = (winner_s == ID_W'(i)) ? req_A[i*WIDTH +: WIDTH] : selA_s;
         selB_s        = (winner_s == ID_W'(i)) ? req_B[i*WIDTH +: WIDTH] : selB_s;
         selOp_s       = (winner_s == ID_W'(i)) ? req_SelOp[i*4 +: 4]     : selOp_s;
         reqReady_s[i] = (state_r == IDLE) & found_s & (winner_s == ID_W'(i));
      end
   end

   // Control FSM plus the operand and response registers; a reset mid-op drops the op.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         lastGrant_r <= PTR_INIT;
         aluA_r      <= '0;
         aluB_r      <= '0;
         aluSelOp_r  <= 4'd0;
         respC_r     <= '0;
         respId_r    <= '0;
         respValid_r <= 1'b0;
         respErr_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (found_s) begin
                  aluA_r      <= selA_s;
                  aluB_r      <= selB_s;
                  aluSelOp_r  <= selOp_s;
                  respId_r    <= winner_s;
                  lastGrant_r <= winner_s;
                  state_r     <= EXEC;
               end else begin
                  state_r <= IDLE;
               end
            end
            EXEC: begin
               respC_r     <= alu_C;
               respErr_r   <= (aluSelOp_r > LAST_OP);
               respValid_r <= 1'b1;
               state_r     <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  respValid_r <= 1'b0;
                  state_r     <= IDLE;
               end else begin
                  state_r <= RESP;
               end
            end
            default: begin
               respValid_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign req_ready  = reqReady_s;
   assign alu_A      = aluA_r;
   assign alu_B      = aluB_r;
   assign alu_SelOp  = aluSelOp_r;
   assign resp_valid = respValid_r;
   assign resp_id    = respId_r;
   assign resp_C     = respC_r;
   assign resp_err   = respErr_r;
   assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler: a behavioural ALU and round-robin model predict
// grants and tagged responses; a separate monitor checks each response as it appears.
module tb_alu_rr_scheduler;
   localparam int N = 4;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] c;
      logic        err;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req_valid = '0;
   logic [N-1:0]  req_ready;
   logic [N*32-1:0] req_A = '0;
   logic [N*32-1:0] req_B = '0;
   logic [N*4-1:0]  req_SelOp = '0;
   logic [31:0]   alu_A, alu_B, alu_C;
   logic [3:0]    alu_SelOp;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [1:0]    resp_id;
   logic [31:0]   resp_C;
   logic          resp_err;
   logic          busy;

   int errors = 0;
   int checks = 0;
   int cycle = 0;

   exp_t        expQ[$];
   exp_t        cur;
   logic        seen = 1'b0;
   logic [N-1:0] pend = '0;
   logic [31:0] pA[N];
   logic [31:0] pB[N];
   logic [3:0]  pOp[N];
   int          lastG = N - 1;
   logic        inFlight = 1'b0;
   int          accCycle = 0;
   int          respMode = 1;

   function automatic logic [31:0] aluRef(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
      case (op)
         4'd0:    return ~a;
         4'd1:    return a + b;
         4'd2:    return a - b;
         4'd3:    return a * b;
         4'd4:    return a & b;
         4'd5:    return a | b;
         4'd6:    return a ^ b;
         4'd7:    return a >> 1;
         4'd8:    return a << 1;
         default: return 32'd0;
      endcase
   endfunction

   // Round-robin rule: first pending requester after the last grant, wrapping; -1 if none.
   function automatic int rrPick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         logic [1:0] idx;
         idx = 2'((last + k) % N);
         if (v[idx]) return int'(idx);
      end
      return -1;
   endfunction

   assign alu_C = aluRef(alu_A, alu_B, alu_SelOp);

   alu_rr_scheduler #(.NUM_REQ(N), .ID_W(2), .WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_A(req_A), .req_B(req_B), .req_SelOp(req_SelOp),
      .alu_A(alu_A), .alu_B(alu_B), .alu_SelOp(alu_SelOp), .alu_C(alu_C),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_C(resp_C), .resp_err(resp_err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op);
      pA[i] = a; pB[i] = b; pOp[i] = op; pend[i] = 1'b1;
   endtask

   // One cycle: drive at negedge, check the grant against the model, record acceptance.
   task automatic step();
      int w;
      exp_t e;
      logic [N-1:0] expRdy;
      @(negedge clk);
      req_valid = pend;
      for (int i = 0; i < N; i++) begin
         req_A[i*32 +: 32]   = pA[i];
         req_B[i*32 +: 32]   = pB[i];
         req_SelOp[i*4 +: 4] = pOp[i];
      end
      case (respMode)
         0:       resp_ready = 1'b0;
         1:       resp_ready = 1'b1;
         default: resp_ready = ($urandom_range(0, 1) == 1);
      endcase
      #1;
      w = inFlight ? -1 : rrPick(pend, lastG);
      expRdy = (w < 0) ? '0 : N'(1 << w);
      chk("req_ready", 32'(req_ready), 32'(expRdy));
      if (w >= 0) begin
         e.id  = 2'(w);
         e.c   = aluRef(pA[w], pB[w], pOp[w]);
         e.err = (pOp[w] > 4'd8);
         expQ.push_back(e);
         pend[w]  = 1'b0;
         lastG    = w;
         inFlight = 1'b1;
         accCycle = cycle;
      end
   endtask

   task automatic waitIdle();
      int n = 0;
      while ((pend != '0 || inFlight) && n < 300) begin
         step();
         n++;
      end
      checks++;
      if (pend != '0 || inFlight) begin
         errors++;
         $display("FAIL drain_timeout: pending=%b inFlight=%0d, expected all served", pend, inFlight);
      end
   endtask

   task automatic resetPulse();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = '0;
      pend = '0;
      expQ.delete();
      inFlight = 1'b0;
      lastG = N - 1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   // Response monitor: pops the scoreboard on first sight, then checks hold while stalled.
   initial begin : monitor
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            seen = 1'b0;
         end else if (resp_valid) begin
            if (!seen) begin
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL spurious_resp: got id=%0d C=%0h, expected no response", resp_id, resp_C);
                  cur.id = resp_id; cur.c = resp_C; cur.err = resp_err;
               end else begin
                  cur = expQ.pop_front();
                  chk("latency", 32'(cycle - accCycle), 32'd2);
               end
               seen = 1'b1;
            end
            chk("resp_id", 32'(resp_id), 32'(cur.id));
            chk("resp_C", resp_C, cur.c);
            chk("resp_err", 32'(resp_err), 32'(cur.err));
            if (resp_ready) begin
               seen = 1'b0;
               inFlight = 1'b0;
            end
         end
      end
   end

   initial begin : driver
      for (int i = 0; i < N; i++) begin
         pA[i] = 32'd0; pB[i] = 32'd0; pOp[i] = 4'd0;
      end
      resetPulse();
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_C", resp_C, 32'd0);
      chk("rst_resp_id", 32'(resp_id), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_alu_A", alu_A, 32'd0);
      chk("rst_alu_B", alu_B, 32'd0);
      chk("rst_alu_SelOp", 32'(alu_SelOp), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);

      // T1: single ADD
      respMode = 1;
      issue(0, 32'd15, 32'd13, 4'd1);
      waitIdle();

      // T2: all four requesting, then requester 0 again
      issue(0, 32'd15, 32'd13, 4'd3);
      issue(1, 32'd7, 32'd9, 4'd4);
      issue(2, 32'hF0F0_0000, 32'h0FF0_1234, 4'd5);
      issue(3, 32'h1234_5678, 32'hFFFF_0000, 4'd6);
      waitIdle();
      issue(0, 32'h8000_0001, 32'd0, 4'd7);
      waitIdle();

      // T3: consumer stalls in RESP
      respMode = 0;
      issue(0, 32'h8000_0001, 32'd0, 4'd8);
      issue(1, 32'd100, 32'd3, 4'd2);
      repeat (8) step();
      respMode = 1;
      waitIdle();

      // T4/T5: wraparound, NOT, illegal opcodes
      issue(2, 32'd13, 32'd15, 4'd2);
      issue(3, 32'd15, 32'd0, 4'd0);
      issue(0, 32'd5, 32'd6, 4'b1001);
      issue(1, 32'd5, 32'd6, 4'b1111);
      waitIdle();

      // T6: reset during EXEC discards the op and restores requester 0 priority
      issue(1, 32'd1, 32'd2, 4'd1);
      for (int n = 0; n < 20 && pend[1]; n++) step();
      resetPulse();
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_resp_valid", 32'(resp_valid), 32'd0);
      issue(2, 32'd3, 32'd4, 4'd3);
      issue(0, 32'd3, 32'd4, 4'd1);
      waitIdle();

      // Random traffic with random back-pressure and request withdrawal
      respMode = 2;
      for (int t = 0; t < 600; t++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0)
               issue(i, $urandom, $urandom, 4'($urandom_range(0, 15)));
            else if (pend[i] && $urandom_range(0, 15) == 0)
               pend[i] = 1'b0;
         end
         step();
      end
      respMode = 1;
      waitIdle();
      repeat (3) step();
      chk("leftover_expected", 32'(expQ.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
